panel_input_conditioner: RTL and testbench

Front-end stage of the chroma control path. Takes the raw, bouncing push-buttons from the board and produces the clean mode levels (`Tono`, `color`, `LP`) and single-cycle step pulses (`UP`, `down`) consumed directly by `controldecroma`. Each button is synchronized and debounced, and a mode state machine selects what the step buttons adjust. An optional auto-repeat feature generates step pulses while a button is held.

---
 rtl/panel_input_conditioner.sv | 148 ++++++++++++++
 tb/tb_panel_input_conditioner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/panel_input_conditioner.sv
// Button front end for the chroma path: sync + debounce, mode FSM, step pulses; all outputs registered.
// Optional hold-to-repeat on the step buttons is built only when AUTOREPEAT_EN is defined.
module panel_input_conditioner #(
  parameter int DEB_CYCLES = 500000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_mode,
  output logic Tono,
  output logic color,
  output logic LP,
  output logic UP,
  output logic down
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_TONE, S_COLOR_L, S_COLOR_P} state_t;

  // Bit order everywhere: [0]=up, [1]=down, [2]=mode.
  logic [2:0]    w_raw;
  logic [2:0]    r_s1, r_s2, r_deb, r_deb_d;
  logic [CW-1:0] r_cnt [3];
  logic [2:0]    w_press;
  state_t        r_state, w_state_nxt;
  logic          w_up_ev, w_dn_ev, w_mode_ev;
  logic          w_step_ok, w_up_step, w_dn_step;
  logic          w_up_rep, w_dn_rep;
  logic          r_tono, r_color, r_lp, r_up, r_down;

  assign w_raw = {btn_mode, btn_down, btn_up};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press   = r_deb & ~r_deb_d;
  assign w_up_ev   = w_press[0];
  assign w_dn_ev   = w_press[1];
  assign w_mode_ev = w_press[2];

  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_ev) begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_TONE;
        S_TONE:    w_state_nxt = S_COLOR_L;
        S_COLOR_L: w_state_nxt = S_COLOR_P;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A mode press wins over a coincident step press; opposing step presses cancel.
  assign w_step_ok = (r_state != S_IDLE) && !w_mode_ev;
  assign w_up_step = w_step_ok && w_up_ev && !w_dn_ev;
  assign w_dn_step = w_step_ok && w_dn_ev && !w_up_ev;

`ifdef AUTOREPEAT_EN
  logic [31:0] r_rep_cnt;
  logic        r_rep_act, r_rep_first, r_rep_dir;
  logic        w_rep_hold, w_rep_fire;
  logic [31:0] w_rep_lim;

  // Repeat stays armed only while its own button alone is held in an active mode.
  assign w_rep_hold = r_rep_act && (r_state != S_IDLE) && !w_mode_ev &&
                      (r_rep_dir ? (r_deb[0] && !r_deb[1]) : (r_deb[1] && !r_deb[0]));
  assign w_rep_lim  = r_rep_first ? 32'(REP_DELAY - 1) : 32'(REP_PERIOD - 1);
  assign w_rep_fire = w_rep_hold && (r_rep_cnt == w_rep_lim);
  assign w_up_rep   = w_rep_fire && r_rep_dir;
  assign w_dn_rep   = w_rep_fire && !r_rep_dir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rep_cnt   <= '0;
      r_rep_act   <= 1'b0;
      r_rep_first <= 1'b0;
      r_rep_dir   <= 1'b0;
    end else if (w_up_step || w_dn_step) begin
      r_rep_cnt   <= '0;
      r_rep_act   <= 1'b1;
      r_rep_first <= 1'b1;
      r_rep_dir   <= w_up_step;
    end else if (!w_rep_hold) begin
      r_rep_cnt   <= '0;
      r_rep_act   <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt   <= r_rep_cnt + 32'd1;
    end
  end
`else
  assign w_up_rep = 1'b0;
  assign w_dn_rep = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tono  <= 1'b0;
      r_color <= 1'b0;
      r_lp    <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tono  <= (w_state_nxt == S_TONE);
      r_color <= (w_state_nxt == S_COLOR_L) || (w_state_nxt == S_COLOR_P);
      r_lp    <= (w_state_nxt == S_COLOR_L);
      r_up    <= w_up_step || w_up_rep;
      r_down  <= w_dn_step || w_dn_rep;
    end
  end

  assign Tono  = r_tono;
  assign color = r_color;
  assign LP    = r_lp;
  assign UP    = r_up;
  assign down  = r_down;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Directed bench for panel_input_conditioner with DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3.
module tb_panel_input_conditioner;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_mode = 1'b0;
  logic Tono, color, LP, UP, down;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int up_cnt = 0;
  int dn_cnt = 0;
  int up_times[$];

  panel_input_conditioner #(
    .DEB_CYCLES(4),
    .REP_DELAY (10),
    .REP_PERIOD(3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .btn_mode(btn_mode),
    .Tono    (Tono),
    .color   (color),
    .LP      (LP),
    .UP      (UP),
    .down    (down)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (UP) begin
      up_cnt++;
      up_times.push_back(cyc);
    end
    if (down) dn_cnt++;
    if (UP && down) begin
      miscompares++;
      $display("FAIL up_down_exclusive: both high at cycle %0d, required at most one", cyc);
    end
  end

  typedef struct {
    logic       u, d, m;
    logic [2:0] exp_mode;
    int         exp_up, exp_dn;
  } vec_t;

  vec_t tbl[11];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    up_cnt = 0;
    dn_cnt = 0;
    up_times.delete();
  endtask

  task automatic press(input logic u, input logic d, input logic m, input int hold, input int gap);
    btn_up = u; btn_down = d; btn_mode = m;
    tick(hold);
    btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
    tick(gap);
  endtask

  task automatic mode_step(input logic [2:0] prev, input logic [2:0] exp);
    btn_mode = 1'b1;
    tick(6);
    chk("mode_before_edge6", {Tono, color, LP}, prev);
    tick(1);
    chk("mode_at_edge6", {Tono, color, LP}, exp);
    tick(13);
    btn_mode = 1'b0;
    tick(12);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  int c0;
  int exp_rep[$];

  initial begin
    tbl[0]  = '{u:1, d:0, m:0, exp_mode:3'b000, exp_up:0, exp_dn:0};
    tbl[1]  = '{u:0, d:0, m:1, exp_mode:3'b100, exp_up:0, exp_dn:0};
    tbl[2]  = '{u:1, d:0, m:0, exp_mode:3'b100, exp_up:1, exp_dn:0};
    tbl[3]  = '{u:0, d:1, m:0, exp_mode:3'b100, exp_up:0, exp_dn:1};
    tbl[4]  = '{u:0, d:0, m:1, exp_mode:3'b011, exp_up:0, exp_dn:0};
    tbl[5]  = '{u:0, d:1, m:0, exp_mode:3'b011, exp_up:0, exp_dn:1};
    tbl[6]  = '{u:1, d:0, m:1, exp_mode:3'b010, exp_up:0, exp_dn:0};
    tbl[7]  = '{u:1, d:1, m:0, exp_mode:3'b010, exp_up:0, exp_dn:0};
    tbl[8]  = '{u:0, d:1, m:0, exp_mode:3'b010, exp_up:0, exp_dn:1};
    tbl[9]  = '{u:0, d:0, m:1, exp_mode:3'b000, exp_up:0, exp_dn:0};
    tbl[10] = '{u:0, d:1, m:0, exp_mode:3'b000, exp_up:0, exp_dn:0};

    // Reset held with all buttons pressed
    tick(3);
    btn_up = 1'b1; btn_down = 1'b1; btn_mode = 1'b1;
    tick(4);
    chk("reset_modes", {Tono, color, LP}, 3'b000);
    chk("reset_steps", {UP, down}, 2'b00);
    clr_counts();
    reset_n = 1'b1;
    tick(6);
    chk("reset_rel_tono_early", Tono, 1'b0);
    tick(1);
    chk("reset_rel_tono", {Tono, color, LP}, 3'b100);
    btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
    tick(20);
    chk("reset_rel_up_cnt", up_cnt, 0);
    chk("reset_rel_dn_cnt", dn_cnt, 0);

    // Mode cycling with exact change timing
    do_reset();
    mode_step(3'b000, 3'b100);
    mode_step(3'b100, 3'b011);
    mode_step(3'b011, 3'b010);
    mode_step(3'b010, 3'b000);

    // Table of press sequences starting from IDLE
    for (int i = 0; i < 11; i++) begin
      clr_counts();
      press(tbl[i].u, tbl[i].d, tbl[i].m, 8, 14);
      chk($sformatf("tbl%0d_mode", i), {Tono, color, LP}, tbl[i].exp_mode);
      chk($sformatf("tbl%0d_up", i), up_cnt, tbl[i].exp_up);
      chk($sformatf("tbl%0d_dn", i), dn_cnt, tbl[i].exp_dn);
    end

    // Bounce rejection in TONE
    press(1'b0, 1'b0, 1'b1, 8, 14);
    chk("bounce_in_tone", {Tono, color, LP}, 3'b100);
    clr_counts();
    for (int k = 0; k < 5; k++) begin
      btn_up = 1'b1; tick(2);
      btn_up = 1'b0; tick(2);
    end
    btn_up = 1'b1;
    c0 = cyc;
    tick(20);
    btn_up = 1'b0;
    tick(14);
    chk("bounce_first_pulse_cycle", (up_times.size() > 0) ? up_times[0] : 0, c0 + 7);
`ifdef AUTOREPEAT_EN
    chk("bounce_up_cnt", up_cnt, 5);
`else
    chk("bounce_up_cnt", up_cnt, 1);
`endif

    // Hold for 30 cycles in TONE
    clr_counts();
`ifdef AUTOREPEAT_EN
    exp_rep = '{0, 10, 13, 16, 19, 22, 25, 28};
`else
    exp_rep = '{0};
`endif
    btn_up = 1'b1;
    tick(30);
    btn_up = 1'b0;
    tick(16);
    chk("hold_up_cnt", up_cnt, exp_rep.size());
    for (int k = 0; k < exp_rep.size(); k++) begin
      chk($sformatf("hold_pulse%0d_rel", k),
          (k < up_times.size()) ? up_times[k] - up_times[0] : -1, exp_rep[k]);
    end

    // Reset mid-operation in COLOR_L with down held
    press(1'b0, 1'b0, 1'b1, 8, 14);
    chk("midrst_in_color_l", {Tono, color, LP}, 3'b011);
    btn_down = 1'b1;
    tick(10);
    clr_counts();
    reset_n = 1'b0;
    #1;
    chk("midrst_async_clear", {Tono, color, LP, UP, down}, 5'b00000);
    tick(1);
    reset_n = 1'b1;
    tick(20);
    chk("midrst_idle_modes", {Tono, color, LP}, 3'b000);
    chk("midrst_no_down", dn_cnt, 0);
    btn_down = 1'b0;
    tick(12);
    press(1'b0, 1'b0, 1'b1, 8, 14);
    chk("midrst_next_is_tone", {Tono, color, LP}, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
